// File: rtl/maze_row_arbiter_if.sv
// Request/return bundle between the two maze-row readers, the arbiter and the row memory.
// The arbiter takes the slave view; the requesters and the memory take the master view.
interface maze_row_arbiter_if #(
  parameter int unsigned COLS  = 80,
  parameter int unsigned ROW_W = 6
) ();
  logic             vid_req;
  logic [ROW_W-1:0] vid_row;
  logic             vid_grant;
  logic             vid_valid;
  logic [COLS-1:0]  vid_data;

  logic             ply_req;
  logic [ROW_W-1:0] ply_row;
  logic             ply_grant;
  logic             ply_valid;
  logic [COLS-1:0]  ply_data;

  logic [ROW_W-1:0] mem_addr;
  logic             mem_rden;
  logic [COLS-1:0]  mem_q;

  modport master (
    output vid_req, vid_row, ply_req, ply_row, mem_q,
    input  vid_grant, vid_valid, vid_data, ply_grant, ply_valid, ply_data, mem_addr, mem_rden
  );

  modport slave (
    input  vid_req, vid_row, ply_req, ply_row, mem_q,
    output vid_grant, vid_valid, vid_data, ply_grant, ply_valid, ply_data, mem_addr, mem_rden
  );
endinterface

// File: rtl/maze_row_arbiter.sv
// Shares the single-port maze row memory between the video renderer (fixed priority) and the
// player collision checker, with a starvation guard and a tag pipeline routing returns.
module maze_row_arbiter #(
  parameter int unsigned ROWS       = 60,
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROW_W      = 6,
  parameter int unsigned READ_LAT   = 2,
  parameter int unsigned STARVE_MAX = 15
) (
  input logic              CLOCK_50,
  input logic              reset,
  maze_row_arbiter_if.slave bus
);

  localparam int unsigned WAIT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {WinNone, WinVid, WinPly} win_e;

  typedef struct packed {
    logic vld;
    logic ply;
    logic oob;
  } tag_t;

  logic             vid_grant_q, ply_grant_q;
  logic             vid_valid_q, ply_valid_q;
  logic [COLS-1:0]  vid_data_q, ply_data_q;
  logic [ROW_W-1:0] mem_addr_q;
  logic             mem_rden_q;
  logic [WAIT_W-1:0] ply_wait_q, ply_wait_d;
  tag_t [READ_LAT:0] tag_q;

  win_e             win;
  logic             vid_elig, ply_elig, starved, sel_oob;
  logic [ROW_W-1:0] sel_row;
  tag_t             tag_new;
  tag_t             tag_ret;

  // A requester whose grant is visible this cycle is still holding its old request.
  always_comb begin
    vid_elig = bus.vid_req & ~vid_grant_q;
    ply_elig = bus.ply_req & ~ply_grant_q;
    starved  = (ply_wait_q == WAIT_W'(STARVE_MAX));

    win = WinNone;
    if (ply_elig && (!vid_elig || starved)) begin
      win = WinPly;
    end else if (vid_elig) begin
      win = WinVid;
    end

    sel_row = (win == WinPly) ? bus.ply_row : bus.vid_row;
    sel_oob = (32'(sel_row) >= ROWS);

    ply_wait_d = ply_wait_q;
    if (!bus.ply_req || win == WinPly) begin
      ply_wait_d = '0;
    end else if (ply_elig && !starved) begin
      ply_wait_d = ply_wait_q + WAIT_W'(1);
    end

    tag_new.vld = (win != WinNone);
    tag_new.ply = (win == WinPly);
    tag_new.oob = sel_oob;
    tag_ret     = tag_q[READ_LAT];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      vid_grant_q <= 1'b0;
      ply_grant_q <= 1'b0;
      vid_valid_q <= 1'b0;
      ply_valid_q <= 1'b0;
      vid_data_q  <= '0;
      ply_data_q  <= '0;
      mem_addr_q  <= '0;
      mem_rden_q  <= 1'b0;
      ply_wait_q  <= '0;
      tag_q       <= '0;
    end else begin
      vid_grant_q <= (win == WinVid);
      ply_grant_q <= (win == WinPly);
      mem_rden_q  <= (win != WinNone) && !sel_oob;
      if (win != WinNone) begin
        mem_addr_q <= sel_oob ? '0 : sel_row;
      end
      ply_wait_q <= ply_wait_d;

      // Stage k holds the tag of the read issued k+1 cycles ago; the last stage lines up with mem_q.
      tag_q <= {tag_q[READ_LAT-1:0], tag_new};

      vid_valid_q <= tag_ret.vld & ~tag_ret.ply;
      ply_valid_q <= tag_ret.vld & tag_ret.ply;
      if (tag_ret.vld) begin
        if (tag_ret.ply) begin
          ply_data_q <= tag_ret.oob ? '0 : bus.mem_q;
        end else begin
          vid_data_q <= tag_ret.oob ? '0 : bus.mem_q;
        end
      end
    end
  end

  assign bus.vid_grant = vid_grant_q;
  assign bus.ply_grant = ply_grant_q;
  assign bus.vid_valid = vid_valid_q;
  assign bus.ply_valid = ply_valid_q;
  assign bus.vid_data  = vid_data_q;
  assign bus.ply_data  = ply_data_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rden  = mem_rden_q;

endmodule
